// File: rtl/enybul_app.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : enybul_app                                                  |
// | Description : Enemy bullet responder. Launches one bullet per fire        |
// |               request, steps it on step_tick and retires it on a hit, a   |
// |               collision or the grid edge, followed by a cooldown.         |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module enybul_app #(
    parameter int X_MAX          = 16,
    parameter int Y_MAX          = 20,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_tick,
    input  logic       enybul_state,
    input  logic       tank_state,
    input  logic [4:0] enytank_xpos,
    input  logic [4:0] enytank_ypos,
    input  logic [1:0] tank_dir,
    input  logic [4:0] mytank_xpos,
    input  logic [4:0] mytank_ypos,
    input  logic       mybul_state,
    input  logic [4:0] mybul_x,
    input  logic [4:0] mybul_y,
    output logic       enybul_state_feedback,
    output logic [4:0] enybul_x,
    output logic [4:0] enybul_y,
    output logic [1:0] enybul_dir,
    output logic       enybul_visible,
    output logic       mytank_hit,
    output logic       bul_collide
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FLY  = 2'd1;
    localparam logic [1:0] ST_COOL = 2'd2;

    localparam logic [1:0] C_DIR_UP    = 2'b00;
    localparam logic [1:0] C_DIR_DOWN  = 2'b01;
    localparam logic [1:0] C_DIR_LEFT  = 2'b10;

    localparam logic [4:0] C_X_MAX     = 5'(X_MAX);
    localparam logic [4:0] C_Y_MAX     = 5'(Y_MAX);
    localparam logic [2:0] C_COOL_LOAD = 3'(COOLDOWN_TICKS);

    logic [1:0] r_state;
    logic [2:0] r_cnt;

    logic       w_hit;
    logic       w_collide;
    logic       w_edge;
    logic [4:0] w_next_x;
    logic [4:0] w_next_y;

    // Edge test uses >= so an out-of-range launch cell can never wrap.
    always_comb begin
        w_hit     = (enybul_x == mytank_xpos) && (enybul_y == mytank_ypos);
        w_collide = mybul_state && (enybul_x == mybul_x) && (enybul_y == mybul_y);
        w_next_x  = enybul_x;
        w_next_y  = enybul_y;
        w_edge    = 1'b0;
        case (enybul_dir)
            C_DIR_UP: begin
                if (enybul_y == 5'd0) w_edge = 1'b1;
                else                  w_next_y = enybul_y - 5'd1;
            end
            C_DIR_DOWN: begin
                if (enybul_y >= C_Y_MAX) w_edge = 1'b1;
                else                     w_next_y = enybul_y + 5'd1;
            end
            C_DIR_LEFT: begin
                if (enybul_x == 5'd0) w_edge = 1'b1;
                else                  w_next_x = enybul_x - 5'd1;
            end
            default: begin
                if (enybul_x >= C_X_MAX) w_edge = 1'b1;
                else                     w_next_x = enybul_x + 5'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            enybul_x    <= 5'd0;
            enybul_y    <= 5'd0;
            enybul_dir  <= 2'd0;
            mytank_hit  <= 1'b0;
            bul_collide <= 1'b0;
        end else begin
            mytank_hit  <= 1'b0;
            bul_collide <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A coincident step_tick is deliberately not used here.
                    if (enybul_state && tank_state) begin
                        enybul_x   <= enytank_xpos;
                        enybul_y   <= enytank_ypos;
                        enybul_dir <= tank_dir;
                        r_state    <= ST_FLY;
                    end
                end
                ST_FLY: begin
                    if (w_hit) begin
                        mytank_hit <= 1'b1;
                        r_state    <= ST_COOL;
                        r_cnt      <= C_COOL_LOAD;
                    end else if (w_collide) begin
                        bul_collide <= 1'b1;
                        r_state     <= ST_COOL;
                        r_cnt       <= C_COOL_LOAD;
                    end else if (step_tick) begin
                        if (w_edge) begin
                            r_state <= ST_COOL;
                            r_cnt   <= C_COOL_LOAD;
                        end else begin
                            enybul_x <= w_next_x;
                            enybul_y <= w_next_y;
                        end
                    end
                end
                ST_COOL: begin
                    if (r_cnt == 3'd0)  r_state <= ST_IDLE;
                    else if (step_tick) r_cnt   <= r_cnt - 3'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign enybul_state_feedback = (r_state != ST_IDLE);
    assign enybul_visible        = (r_state == ST_FLY);

endmodule
`default_nettype wire

// File: tb/tb_enybul_app.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_enybul_app                                               |
// | Description : Self-checking bench for enybul_app: vector table, corner    |
// |               sequences and random traffic against a reference model.     |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_enybul_app;

    localparam int X_MAX          = 16;
    localparam int Y_MAX          = 20;
    localparam int COOLDOWN_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst, step_tick, enybul_state, tank_state, mybul_state;
    logic [4:0] enytank_xpos, enytank_ypos, mytank_xpos, mytank_ypos, mybul_x, mybul_y;
    logic [1:0] tank_dir;
    logic       enybul_state_feedback, enybul_visible, mytank_hit, bul_collide;
    logic [4:0] enybul_x, enybul_y;
    logic [1:0] enybul_dir;

    int n_cmp = 0;
    int n_err = 0;

    enybul_app #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .COOLDOWN_TICKS(COOLDOWN_TICKS)) dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .enybul_state(enybul_state),
        .tank_state(tank_state), .enytank_xpos(enytank_xpos), .enytank_ypos(enytank_ypos),
        .tank_dir(tank_dir), .mytank_xpos(mytank_xpos), .mytank_ypos(mytank_ypos),
        .mybul_state(mybul_state), .mybul_x(mybul_x), .mybul_y(mybul_y),
        .enybul_state_feedback(enybul_state_feedback), .enybul_x(enybul_x),
        .enybul_y(enybul_y), .enybul_dir(enybul_dir), .enybul_visible(enybul_visible),
        .mytank_hit(mytank_hit), .bul_collide(bul_collide)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = flying, 2 = cooling down.
    int m_mode = 0, m_x = 0, m_y = 0, m_dir = 0, m_cnt = 0;
    bit m_hit = 0, m_col = 0;

    task automatic model_edge();
        int dx, dy, nx, ny;
        m_hit = 0;
        m_col = 0;
        if (rst) begin
            m_mode = 0; m_x = 0; m_y = 0; m_dir = 0; m_cnt = 0;
            return;
        end
        if (m_mode == 0) begin
            if (enybul_state && tank_state) begin
                m_x = int'(enytank_xpos); m_y = int'(enytank_ypos);
                m_dir = int'(tank_dir); m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (m_x == int'(mytank_xpos) && m_y == int'(mytank_ypos)) begin
                m_hit = 1; m_mode = 2; m_cnt = COOLDOWN_TICKS;
            end else if (mybul_state && m_x == int'(mybul_x) && m_y == int'(mybul_y)) begin
                m_col = 1; m_mode = 2; m_cnt = COOLDOWN_TICKS;
            end else if (step_tick) begin
                dx = (m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0;
                dy = (m_dir == 1) ? 1 : (m_dir == 0) ? -1 : 0;
                nx = m_x + dx;
                ny = m_y + dy;
                if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
                    m_mode = 2; m_cnt = COOLDOWN_TICKS;
                end else begin
                    m_x = nx; m_y = ny;
                end
            end
        end else begin
            if (m_cnt == 0)     m_mode = 0;
            else if (step_tick) m_cnt = m_cnt - 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare after the edge.
    task automatic cyc();
        logic [15:0] exp_v;
        model_edge();
        @(posedge clk);
        #1;
        exp_v = {m_mode != 0, 5'(m_x), 5'(m_y), 2'(m_dir), m_mode == 1, m_hit, m_col};
        chk("cycle_model", {16'd0, enybul_state_feedback, enybul_x, enybul_y, enybul_dir,
                            enybul_visible, mytank_hit, bul_collide}, {16'd0, exp_v});
    endtask

    task automatic do_reset();
        rst = 1'b1; step_tick = 1'b0; enybul_state = 1'b0; tank_state = 1'b1;
        mybul_state = 1'b0; mybul_x = 5'd31; mybul_y = 5'd31;
        cyc();
        rst = 1'b0;
    endtask

    task automatic launch(input logic [4:0] tx, input logic [4:0] ty, input logic [1:0] d,
                          input logic ts, input logic [4:0] mx, input logic [4:0] my);
        enytank_xpos = tx; enytank_ypos = ty; tank_dir = d; tank_state = ts;
        mytank_xpos = mx; mytank_ypos = my;
        enybul_state = 1'b1;
        cyc();
        enybul_state = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            step_tick = 1'b1; cyc();
            step_tick = 1'b0; cyc();
        end
    endtask

    typedef struct {
        logic [4:0] tx, ty;
        logic [1:0] dir;
        logic       ts;
        logic [4:0] mx, my;
        int         nticks;
        logic [4:0] ex, ey;
        logic       evis, efb;
    } vec_t;

    function automatic vec_t mk(input int tx, ty, d, ts, mx, my, n, ex, ey, ev, ef);
        vec_t v;
        v.tx = 5'(tx); v.ty = 5'(ty); v.dir = 2'(d); v.ts = 1'(ts);
        v.mx = 5'(mx); v.my = 5'(my); v.nticks = n;
        v.ex = 5'(ex); v.ey = 5'(ey); v.evis = 1'(ev); v.efb = 1'(ef);
        return v;
    endfunction

    function automatic logic [4:0] rpos(input int maxv);
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, maxv));
    endfunction

    vec_t vecs[12];
    int   found;

    initial begin
        //            tx ty dir ts mx my ticks ex ey vis fb
        vecs[0]  = mk(5,  5, 3, 1, 16, 20, 3,   8,  5, 1, 1);
        vecs[1]  = mk(5,  5, 3, 1, 16, 20, 12, 16,  5, 0, 1);
        vecs[2]  = mk(5,  5, 3, 1, 16, 20, 13, 16,  5, 0, 1);
        vecs[3]  = mk(5,  5, 3, 1, 16, 20, 14, 16,  5, 0, 0);
        vecs[4]  = mk(3, 10, 0, 1,  3,  6, 3,   3,  7, 1, 1);
        vecs[5]  = mk(3, 10, 0, 1,  3,  6, 4,   3,  6, 0, 1);
        vecs[6]  = mk(0,  0, 2, 1, 16, 20, 0,   0,  0, 1, 1);
        vecs[7]  = mk(0,  0, 2, 1, 16, 20, 1,   0,  0, 0, 1);
        vecs[8]  = mk(2, 20, 1, 1, 16, 20, 1,   2, 20, 0, 1);
        vecs[9]  = mk(4,  4, 1, 1,  4,  4, 0,   4,  4, 0, 1);
        vecs[10] = mk(5,  5, 3, 0, 16, 20, 2,   0,  0, 0, 0);
        vecs[11] = mk(7,  3, 1, 1, 16, 20, 5,   7,  8, 1, 1);

        enytank_xpos = 5'd0; enytank_ypos = 5'd0; tank_dir = 2'd0;
        mytank_xpos = 5'd16; mytank_ypos = 5'd20;
        do_reset();
        chk("reset_outputs", {23'd0, enybul_state_feedback, enybul_x, enybul_y, enybul_dir,
                              enybul_visible, mytank_hit, bul_collide}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            launch(vecs[i].tx, vecs[i].ty, vecs[i].dir, vecs[i].ts, vecs[i].mx, vecs[i].my);
            ticks(vecs[i].nticks);
            chk($sformatf("vec%0d_pos", i), {22'd0, enybul_x, enybul_y}, {22'd0, vecs[i].ex, vecs[i].ey});
            chk($sformatf("vec%0d_vis_fb", i), {30'd0, enybul_visible, enybul_state_feedback},
                {30'd0, vecs[i].evis, vecs[i].efb});
        end

        // Hit pulse is exactly one clock wide.
        do_reset();
        launch(5'd3, 5'd10, 2'b00, 1'b1, 5'd3, 5'd6);
        ticks(3);
        step_tick = 1'b1; cyc(); step_tick = 1'b0; cyc();
        chk("hit_pulse_on", {31'd0, mytank_hit}, 32'd1);
        cyc();
        chk("hit_pulse_off", {30'd0, mytank_hit, enybul_visible}, 32'd0);

        // Collision with my bullet, then both targets on one cell.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            mybul_state = 1'b1; mybul_x = 5'd9; mybul_y = 5'd5;
            launch(5'd8, 5'd5, 2'b11, 1'b1, (k == 0) ? 5'd0 : 5'd9, (k == 0) ? 5'd20 : 5'd5);
            step_tick = 1'b1; cyc(); step_tick = 1'b0; cyc();
            chk($sformatf("collide_case%0d_pulse", k), {30'd0, mytank_hit, bul_collide},
                (k == 0) ? 32'd1 : 32'd2);
            cyc();
            chk($sformatf("collide_case%0d_after", k), {29'd0, mytank_hit, bul_collide, enybul_visible}, 32'd0);
        end
        mybul_state = 1'b0;

        // Request held through a whole flight: one idle clock, then relaunch.
        do_reset();
        enytank_xpos = 5'd14; enytank_ypos = 5'd3; tank_dir = 2'b11;
        mytank_xpos = 5'd0; mytank_ypos = 5'd20; enybul_state = 1'b1;
        cyc();
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            step_tick = (i % 3 == 0);
            cyc();
            if (!enybul_state_feedback) found = 1;
        end
        step_tick = 1'b0;
        chk("held_req_reaches_idle", found, 1);
        cyc();
        chk("held_req_relaunch", {25'd0, enybul_state_feedback, enybul_visible, enybul_x},
            {25'd0, 1'b1, 1'b1, 5'd14});
        enybul_state = 1'b0;

        // Reset in the middle of a flight.
        do_reset();
        launch(5'd6, 5'd6, 2'b01, 1'b1, 5'd16, 5'd0);
        ticks(2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("reset_mid_fly", {16'd0, enybul_state_feedback, enybul_x, enybul_y, enybul_dir,
                              enybul_visible, mytank_hit, bul_collide}, 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            step_tick    = ($urandom_range(0, 2) == 0);
            enybul_state = ($urandom_range(0, 1) == 0);
            tank_state   = ($urandom_range(0, 9) != 0);
            enytank_xpos = rpos(X_MAX);
            enytank_ypos = rpos(Y_MAX);
            tank_dir     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                mytank_xpos = rpos(X_MAX);
                mytank_ypos = rpos(Y_MAX);
            end
            mybul_state  = ($urandom_range(0, 1) == 0);
            mybul_x      = rpos(X_MAX);
            mybul_y      = rpos(Y_MAX);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enybul_app.md
Name: enybul_app

Overview:
- Responder end of the enemy fire handshake: accepts the enemy tank's fire request, launches one bullet from the tank's cell and heading, and steps it across the 17x21 grid.
- Reports busy/free back to the tank through enybul_state_feedback.
- Detects hits on my tank and collisions with my bullet; the bullet is retired on a hit, a collision, or leaving the field.
- One instance per enemy tank, in the game-logic layer beside the tank's application module.

Parameters:
- X_MAX, 16, largest legal x cell index
- Y_MAX, 20, largest legal y cell index
- COOLDOWN_TICKS, 2, step ticks held busy after a bullet retires before a new request is accepted (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- step_tick  in  1  one-clk pulse per movement step (4 Hz rate)
- enybul_state  in  1  fire request from the tank, level
- tank_state  in  1  tank alive
- enytank_xpos  in  5  tank x
- enytank_ypos  in  5  tank y
- tank_dir  in  2  tank heading: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- mytank_xpos  in  5  my tank x
- mytank_ypos  in  5  my tank y
- mybul_state  in  1  my bullet in flight
- mybul_x  in  5  my bullet x
- mybul_y  in  5  my bullet y
- enybul_state_feedback  out  1  1 = bullet slot busy (FLY or COOLDOWN)
- enybul_x  out  5  bullet x
- enybul_y  out  5  bullet y
- enybul_dir  out  2  latched bullet heading
- enybul_visible  out  1  1 only in FLY
- mytank_hit  out  1  one-clk pulse, bullet reached my tank
- bul_collide  out  1  one-clk pulse, bullet met my bullet

Behaviour:
- Reset: state IDLE; all outputs 0; cooldown counter 0. Reset has priority over every other event, including mid-flight and mid-cooldown.
- State IDLE:
  - feedback=0, visible=0.
  - Accept when enybul_state=1 and tank_state=1 on a clk edge.
  - On accept: enybul_x/y <= tank x/y; enybul_dir <= tank_dir; go to FLY.
  - feedback and visible are 1 from the next cycle (latency 1 clk).
- Acceptance rules:
  - Acceptance is level-sensitive and occurs only in IDLE.
  - A request while busy is ignored, not queued.
  - A request with tank_state=0 is ignored.
- Launch vs step_tick: if accept coincides with step_tick, the tick is consumed by the launch. The first move happens on the next step_tick.
- State FLY, checks evaluated every clk in this priority order:
  1. Hit: if enybul_x==mytank_xpos and enybul_y==mytank_ypos, pulse mytank_hit and go to COOLDOWN. This includes the first FLY cycle, so a point-blank launch hits after 1 clk.
  2. Collide: else if mybul_state=1 and enybul_x==mybul_x and enybul_y==mybul_y, pulse bul_collide and go to COOLDOWN.
  3. Move: else on step_tick, move one cell along enybul_dir.
- Boundary on move:
  - If the move would leave the grid (x==0 left, x==X_MAX right, y==0 up, y==Y_MAX down), the bullet retires to COOLDOWN with no pulse and its position unchanged.
  - No 5-bit wrap-around ever occurs.
- Tank death: tank_state falling in FLY does not affect the bullet; it continues flying.
- Pulses: mytank_hit and bul_collide are exactly 1 clk wide and are never asserted together.
- State COOLDOWN:
  - visible=0, feedback=1, position holds its last value.
  - Counter loads COOLDOWN_TICKS on entry and decrements on each step_tick.
  - When the counter is 0, go to IDLE next clk. With COOLDOWN_TICKS=0, COOLDOWN lasts 1 clk.
- feedback drops to 0 the cycle IDLE is entered.
- No checks or moves occur in IDLE or COOLDOWN.

Test Plan:
- Launch and travel: tank (5,5) dir 11 requests fire, my tank at (16,20).
  - feedback=1 one clk after the request.
  - After 3 ticks, enybul=(8,5).
  - Bullet retires on the tick after reaching x=16.
  - feedback=0 after 2 further ticks plus 1 clk.
- Hit: tank (3,10) dir 00, my tank (3,6). After the 4th tick, enybul=(3,6); mytank_hit is a 1-clk pulse, then COOLDOWN with visible=0.
- Collide: bullet at (8,5) dir 11, mybul_state=1 at (9,5). On the next tick, bul_collide pulses; no mytank_hit.
- Simultaneous conditions: bullet lands on a cell holding both my tank and my bullet → only mytank_hit pulses.
- Busy/ignored requests:
  - Hold enybul_state=1 throughout a flight → no relaunch until IDLE; relaunch 1 clk after IDLE is entered.
  - tank_state=0 with a request → stays IDLE.
- Edge and reset cases:
  - Launch at (0,0) dir 10 → retires on the first tick.
  - Assert rst mid-FLY → next clk all outputs 0, state IDLE.
